// File: rtl/hazard_ctrl_pkg.sv
// Shared ISA opcode constants and hazard sequencer state encoding.
// Imported by the ID-stage decoder as well as the hazard logic.
package hazard_ctrl_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] LW_1 = 5'b00000;
  localparam logic [OPC_W-1:0] LW_2 = 5'b00001;
  localparam logic [OPC_W-1:0] LW_3 = 5'b00010;
  localparam logic [OPC_W-1:0] SW   = 5'b00011;
  localparam logic [OPC_W-1:0] ADD  = 5'b00100;
  localparam logic [OPC_W-1:0] SUB  = 5'b00101;
  localparam logic [OPC_W-1:0] MUL  = 5'b01000;
  localparam logic [OPC_W-1:0] DIV  = 5'b01001;
  localparam logic [OPC_W-1:0] BEQ  = 5'b01010;
  localparam logic [OPC_W-1:0] JR   = 5'b01011;
  localparam logic [OPC_W-1:0] CALL = 5'b01100;
  localparam logic [OPC_W-1:0] RET  = 5'b01101;
  localparam logic [OPC_W-1:0] NOP  = 5'b11111;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MULDIV  = 2'd1,
    MEMWAIT = 2'd2
  } hzState_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard sequencer signal bundle.
// The master side is the pipeline datapath; the slave side is hazard_ctrl.
interface hazard_ctrl_if #(parameter int REG_AW = 5);
  logic              id_valid;
  logic [4:0]        id_opcode;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              ex_valid;
  logic [4:0]        ex_opcode;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              ex_branch_taken;
  logic              mem_req;
  logic              mem_ready;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic              ex_hold;
  logic              mem_hold;
  logic              busy;
  logic              mem_err;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, ex_valid, ex_opcode, ex_rd,
           ex_mem_read, ex_branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold,
           mem_hold, busy, mem_err
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, ex_valid, ex_opcode, ex_rd,
           ex_mem_read, ex_branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold,
           mem_hold, busy, mem_err
  );
endinterface

// File: rtl/hazard_ctrl_stall_counter.sv
// Loadable down-counter with freeze and zero flag; tracks remaining MUL/DIV hold cycles.
module stall_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         dec,
  input  logic         freeze,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                               cnt <= '0;
    else if (load)                         cnt <= loadVal;
    else if (dec && !freeze && cnt != '0)  cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard sequencer: stall/bubble/flush strobes for load-use, multi-cycle MUL/DIV,
// data-memory wait states and taken branches, plus a sticky memory-timeout flag.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MUL_LAT     = 3,
  parameter int DIV_LAT     = 8,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT - 1) : 1;
  localparam int WAIT_W  = $clog2(MEM_TIMEOUT);

  localparam logic [CNT_W-1:0]  MUL_LD   = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
  localparam logic [CNT_W-1:0]  DIV_LD   = CNT_W'((DIV_LAT > 1) ? DIV_LAT - 2 : 0);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_PRE = WAIT_W'(MEM_TIMEOUT - 2);
  localparam logic [REG_AW-1:0] R0       = '0;
  localparam bit                MUL_STALL = (MUL_LAT > 1);
  localparam bit                DIV_STALL = (DIV_LAT > 1);

  hzState_e          state, stateNxt, retState, retNxt, effState;
  logic [WAIT_W-1:0] waitCnt;
  logic              memErr;
  logic              memStall, mdStart, loadUse;
  logic              cntLoad, cntDec, cntZero;
  logic [CNT_W-1:0]  cntLdVal;
  logic              pcW, ifIdW, ifIdFlush, idExBubble, exHold, memHold;

  assign memStall = hz.mem_req & ~hz.mem_ready;

  // The cycle memory completes, act as the state we were holding for.
  assign effState = (state == MEMWAIT) ? retState : state;

  assign mdStart = hz.ex_valid &
                   (((hz.ex_opcode == MUL) & MUL_STALL) | ((hz.ex_opcode == DIV) & DIV_STALL));

  assign loadUse = hz.ex_valid & hz.ex_mem_read & hz.id_valid & (hz.id_opcode != NOP) &
                   (hz.ex_rd != R0) & ((hz.ex_rd == hz.id_rs) | (hz.ex_rd == hz.id_rt));

  stall_counter #(.W(CNT_W)) u_mdCnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cntLoad),
    .loadVal (cntLdVal),
    .dec     (cntDec),
    .freeze  (memStall),
    .zero    (cntZero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      retState <= RUN;
    end else begin
      state    <= stateNxt;
      retState <= retNxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt <= '0;
      memErr  <= 1'b0;
    end else if (memStall) begin
      if (waitCnt != WAIT_MAX) waitCnt <= waitCnt + WAIT_W'(1);
      if (waitCnt >= WAIT_PRE) memErr  <= 1'b1;
    end else begin
      waitCnt <= '0;
    end
  end

  always_comb begin
    pcW        = 1'b1;
    ifIdW      = 1'b1;
    ifIdFlush  = 1'b0;
    idExBubble = 1'b0;
    exHold     = 1'b0;
    memHold    = 1'b0;
    stateNxt   = RUN;
    retNxt     = retState;
    cntLoad    = 1'b0;
    cntDec     = 1'b0;
    cntLdVal   = MUL_LD;

    if (memStall) begin
      pcW      = 1'b0;
      ifIdW    = 1'b0;
      exHold   = 1'b1;
      memHold  = 1'b1;
      stateNxt = MEMWAIT;
      if (state != MEMWAIT) retNxt = state;
    end else begin
      case (effState)
        MULDIV: begin
          if (!cntZero) begin
            pcW      = 1'b0;
            ifIdW    = 1'b0;
            exHold   = 1'b1;
            cntDec   = 1'b1;
            stateNxt = MULDIV;
          end
        end
        default: begin
          if (mdStart) begin
            // First EX cycle is this one; the counter covers the remaining LAT-2 holds.
            pcW      = 1'b0;
            ifIdW    = 1'b0;
            exHold   = 1'b1;
            cntLoad  = 1'b1;
            cntLdVal = (hz.ex_opcode == DIV) ? DIV_LD : MUL_LD;
            stateNxt = MULDIV;
          end else if (hz.ex_branch_taken) begin
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
          end else if (loadUse) begin
            pcW        = 1'b0;
            ifIdW      = 1'b0;
            idExBubble = 1'b1;
          end
        end
      endcase
    end

    if (rst) begin
      pcW        = 1'b0;
      ifIdW      = 1'b0;
      ifIdFlush  = 1'b1;
      idExBubble = 1'b1;
      exHold     = 1'b0;
      memHold    = 1'b0;
    end
  end

  assign hz.pc_write     = pcW;
  assign hz.if_id_write  = ifIdW;
  assign hz.if_id_flush  = ifIdFlush;
  assign hz.id_ex_bubble = idExBubble;
  assign hz.ex_hold      = exHold;
  assign hz.mem_hold     = memHold;
  assign hz.busy         = (state != RUN) & ~rst;
  assign hz.mem_err      = memErr;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl: two parameterizations against an occupancy-based model,
// plus directed scenarios with hand-computed expectations.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          idValid, exValid, exMemRead, exBr, memReq, memRdy;
  logic [4:0]    idOp, exOp;
  logic [AW-1:0] idRs, idRt, exRd;

  hazard_ctrl_if #(.REG_AW(AW)) hzA ();
  hazard_ctrl_if #(.REG_AW(AW)) hzB ();

  assign hzA.id_valid = idValid;   assign hzB.id_valid = idValid;
  assign hzA.id_opcode = idOp;     assign hzB.id_opcode = idOp;
  assign hzA.id_rs = idRs;         assign hzB.id_rs = idRs;
  assign hzA.id_rt = idRt;         assign hzB.id_rt = idRt;
  assign hzA.ex_valid = exValid;   assign hzB.ex_valid = exValid;
  assign hzA.ex_opcode = exOp;     assign hzB.ex_opcode = exOp;
  assign hzA.ex_rd = exRd;         assign hzB.ex_rd = exRd;
  assign hzA.ex_mem_read = exMemRead;     assign hzB.ex_mem_read = exMemRead;
  assign hzA.ex_branch_taken = exBr;      assign hzB.ex_branch_taken = exBr;
  assign hzA.mem_req = memReq;     assign hzB.mem_req = memReq;
  assign hzA.mem_ready = memRdy;   assign hzB.mem_ready = memRdy;

  hazard_ctrl #(.REG_AW(AW), .MUL_LAT(3), .DIV_LAT(8), .MEM_TIMEOUT(64)) uA (
    .clk(clk), .rst(rst), .hz(hzA));
  hazard_ctrl #(.REG_AW(AW), .MUL_LAT(1), .DIV_LAT(2), .MEM_TIMEOUT(2)) uB (
    .clk(clk), .rst(rst), .hz(hzB));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a multi-cycle op is tracked by how many non-stalled EX cycles it has used;
  // run counts consecutive memory-stall cycles.
  typedef struct packed {
    bit md;
    int occ;
    int lat;
    int run;
    bit err;
  } mdl_t;

  typedef struct packed {
    logic pc, ifid, flush, bub, exh, memh, busy, err;
  } outs_t;

  function automatic void mstep(input int mulLat, input int divLat, input int mto,
                                input mdl_t m, output mdl_t n, output outs_t o);
    bit stall;
    n = m;
    o = '0;
    o.pc = 1'b1;
    o.ifid = 1'b1;
    o.err = m.err;
    stall = memReq && !memRdy;
    if (rst) begin
      o.pc = 1'b0; o.ifid = 1'b0; o.flush = 1'b1; o.bub = 1'b1;
      n = '0;
      return;
    end
    o.busy = (m.run > 0) || m.md;
    if (stall) begin
      o.pc = 1'b0; o.ifid = 1'b0; o.exh = 1'b1; o.memh = 1'b1;
      n.run = (m.run < mto) ? m.run + 1 : m.run;
      if (n.run >= mto - 1) n.err = 1'b1;
    end else begin
      n.run = 0;
      if (m.md) begin
        n.occ = m.occ + 1;
        if (n.occ < m.lat) begin o.pc = 1'b0; o.ifid = 1'b0; o.exh = 1'b1; end
        else n.md = 1'b0;
      end else if (exValid && ((exOp == MUL && mulLat > 1) || (exOp == DIV && divLat > 1))) begin
        o.pc = 1'b0; o.ifid = 1'b0; o.exh = 1'b1;
        n.md = 1'b1;
        n.occ = 1;
        n.lat = (exOp == MUL) ? mulLat : divLat;
      end else if (exBr) begin
        o.flush = 1'b1; o.bub = 1'b1;
      end else if (exValid && exMemRead && idValid && idOp != NOP && exRd != '0 &&
                   (exRd == idRs || exRd == idRt)) begin
        o.pc = 1'b0; o.ifid = 1'b0; o.bub = 1'b1;
      end
    end
  endfunction

  mdl_t mA = '0;
  mdl_t mB = '0;
  bit running = 1'b1;

  always @(negedge clk) begin : cmp
    outs_t eA, eB;
    mdl_t nA, nB;
    if (running) begin
      mstep(3, 8, 64, mA, nA, eA);
      mstep(1, 2, 2, mB, nB, eB);
      chk("cycA", {hzA.pc_write, hzA.if_id_write, hzA.if_id_flush, hzA.id_ex_bubble,
                   hzA.ex_hold, hzA.mem_hold, hzA.busy, hzA.mem_err}, eA);
      chk("cycB", {hzB.pc_write, hzB.if_id_write, hzB.if_id_flush, hzB.id_ex_bubble,
                   hzB.ex_hold, hzB.mem_hold, hzB.busy, hzB.mem_err}, eB);
      mA = nA;
      mB = nB;
    end
  end

  task automatic idle();
    idValid = 0; idOp = NOP; idRs = '0; idRt = '0;
    exValid = 0; exOp = NOP; exRd = '0; exMemRead = 0; exBr = 0;
    memReq = 0; memRdy = 1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    adv();
  endtask

  function automatic logic [4:0] pickOp();
    case ($urandom_range(0, 8))
      0: return LW_1;
      1: return LW_2;
      2: return LW_3;
      3: return ADD;
      4: return MUL;
      5: return DIV;
      6: return JR;
      7: return NOP;
      default: return 5'($urandom);
    endcase
  endfunction

  task automatic randIn();
    rst       = ($urandom_range(0, 199) == 0);
    idValid   = ($urandom_range(0, 3) != 0);
    idOp      = pickOp();
    idRs      = AW'($urandom_range(0, 7));
    idRt      = AW'($urandom_range(0, 7));
    exValid   = ($urandom_range(0, 3) != 0);
    exOp      = pickOp();
    exRd      = AW'($urandom_range(0, 7));
    exMemRead = ($urandom_range(0, 2) == 0);
    exBr      = ($urandom_range(0, 5) == 0);
    memReq    = ($urandom_range(0, 3) == 0);
    memRdy    = ($urandom_range(0, 1) == 1);
  endtask

  initial begin
    int holds, bh, ns, mh, len;
    rst = 1; idle();
    @(negedge clk);
    chk("rst_outs", {hzA.pc_write, hzA.if_id_write, hzA.if_id_flush, hzA.id_ex_bubble,
                     hzA.ex_hold, hzA.mem_hold, hzA.busy}, 7'b0011000);
    chk("rst_err", hzA.mem_err, 0);
    adv();
    rst = 0;

    // load-use
    exValid = 1; exOp = LW_1; exMemRead = 1; exRd = 3; idValid = 1; idOp = ADD; idRs = 3; idRt = 5;
    @(negedge clk);
    chk("lu_hit", {hzA.pc_write, hzA.if_id_write, hzA.id_ex_bubble}, 3'b001);
    adv();
    exRd = 0;
    @(negedge clk);
    chk("lu_rd0", {hzA.pc_write, hzA.if_id_write, hzA.id_ex_bubble}, 3'b110);
    adv();
    exOp = LW_3; exRd = 5;
    @(negedge clk);
    chk("lu_lw3_rt", {hzA.pc_write, hzA.if_id_write, hzA.id_ex_bubble}, 3'b001);
    adv();

    // DIV with DIV_LAT=8
    idle(); exValid = 1; exOp = DIV;
    holds = 0; bh = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      holds += int'(hzA.ex_hold);
      bh += int'(hzA.ex_hold & hzA.busy);
      if (i == 7) chk("div_release", hzA.ex_hold, 0);
      adv();
    end
    chk("div_holds", holds, 7);
    chk("div_busy_holds", bh, 6);

    // MUL: MUL_LAT=3 on A, MUL_LAT=1 on B
    exOp = MUL; holds = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) chk("mul_lat1_nohold", hzB.ex_hold, 0);
      holds += int'(hzA.ex_hold);
      adv();
    end
    chk("mul_holds", holds, 2);

    // taken branch with a simultaneous load-use match
    idle(); exValid = 1; exOp = JR; exBr = 1; exMemRead = 1; exRd = 3;
    idValid = 1; idOp = ADD; idRs = 3;
    @(negedge clk);
    chk("br_flush", {hzA.pc_write, hzA.if_id_write, hzA.if_id_flush, hzA.id_ex_bubble}, 4'b1111);
    adv();
    idle();
    @(negedge clk);
    chk("br_after", {hzA.pc_write, hzA.if_id_write, hzA.if_id_flush, hzA.id_ex_bubble}, 4'b1100);
    adv();

    // memory stall of 5 cycles in the middle of a MUL
    idle(); exValid = 1; exOp = MUL;
    holds = 0; ns = 0; mh = 0;
    for (int i = 0; i < 8; i++) begin
      memReq = (i >= 1 && i <= 6);
      memRdy = !(i >= 1 && i <= 5);
      @(negedge clk);
      holds += int'(hzA.ex_hold);
      if (!(i >= 1 && i <= 5)) ns += int'(hzA.ex_hold);
      mh += int'(hzA.mem_hold);
      if (i == 7) chk("md_mem_release", hzA.ex_hold, 0);
      adv();
    end
    chk("md_mem_total", holds, 7);
    chk("md_mem_exec", ns, 2);
    chk("md_mem_memhold", mh, 5);

    // memory timeout
    idle(); memReq = 1; memRdy = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 62) chk("to_before", hzA.mem_err, 0);
      if (i == 63) chk("to_after", hzA.mem_err, 1);
      adv();
    end
    memRdy = 1;
    @(negedge clk);
    chk("to_ready_sticky", hzA.mem_err, 1);
    adv();
    memReq = 0;
    repeat (3) cyc();
    @(negedge clk);
    chk("to_still", hzA.mem_err, 1);
    adv();
    rst = 1;
    cyc();
    rst = 0;
    @(negedge clk);
    chk("to_rst_clear", hzA.mem_err, 0);
    adv();

    // reset while DIV counter sits at 4
    idle(); exValid = 1; exOp = DIV;
    cyc(); cyc();
    @(negedge clk);
    chk("md_busy_pre", hzA.busy, 1);
    adv();
    rst = 1;
    @(negedge clk);
    chk("rst_md_busy", hzA.busy, 0);
    adv();
    rst = 0;
    holds = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j == 0) chk("rst_md_run", {hzA.busy, hzA.ex_hold}, 2'b01);
      holds += int'(hzA.ex_hold);
      adv();
    end
    chk("rst_md_restart", holds, 7);

    // randomized traffic with occasional long memory stalls
    for (int k = 0; k < 4000; k++) begin
      randIn();
      if ($urandom_range(0, 299) == 0) begin
        len = $urandom_range(55, 70);
        for (int s = 0; s < len; s++) begin
          randIn();
          rst = 0; memReq = 1; memRdy = 0;
          cyc();
        end
        randIn();
      end
      cyc();
    end

    running = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
